// File: rtl/sram_controller.sv
// Sequences one 32-bit load/store as two 16-bit half-word accesses on an
// external SRAM. Optional range check: define SRAM_CTRL_BOUNDS_CHECK_EN.
module sram_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  inout  wire  [15:0] sram_data,
  output logic        sram_write_en
);

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    WAIT,
    DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_is_write;
  logic [31:0] r_wait_cnt;
  logic [31:0] r_read_data;

  logic        w_req;
  logic        w_in_range;
  logic [16:0] w_index;
  logic        w_drive;
  logic [15:0] w_drive_data;

  assign w_req = wr_en | rd_en;

  // Out-of-window requests bypass the SRAM entirely and complete in one cycle.
`ifdef SRAM_CTRL_BOUNDS_CHECK_EN
  assign w_in_range = ({1'b0, address} >= {1'b0, BASE_ADDR}) &&
                      ({1'b0, address} <  ({1'b0, BASE_ADDR} + 33'h0_0008_0000));
`else
  assign w_in_range = 1'b1;
`endif

  assign w_index = 17'((r_addr - BASE_ADDR) >> 2);

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next    = r_state;
    sram_addr = '0;
    w_drive   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req) w_next = w_in_range ? LOW : DONE;
      end
      LOW: begin
        w_next    = HIGH;
        sram_addr = {w_index, 1'b0};
        w_drive   = r_is_write;
      end
      HIGH: begin
        w_next    = (WAIT_CYCLES > 0) ? WAIT : DONE;
        sram_addr = {w_index, 1'b1};
        w_drive   = r_is_write;
      end
      WAIT: begin
        if (r_wait_cnt == WAIT_CYCLES - 1) w_next = DONE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign ready         = (r_state == DONE) || ((r_state == IDLE) && !w_req);
  assign w_drive_data  = (r_state == HIGH) ? r_wdata[31:16] : r_wdata[15:0];
  assign sram_write_en = ~w_drive;
  assign sram_data     = w_drive ? w_drive_data : 16'hzzzz;
  assign read_data     = r_read_data;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_wait_cnt  <= '0;
      r_read_data <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_is_write  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr     <= address;
            r_wdata    <= write_data;
            r_is_write <= wr_en;
            r_wait_cnt <= '0;
            if (!w_in_range && !wr_en) r_read_data <= '0;
          end
        end
        LOW: begin
          if (!r_is_write) r_read_data[15:0] <= sram_data;
        end
        HIGH: begin
          if (!r_is_write) r_read_data[31:16] <= sram_data;
          r_wait_cnt <= '0;
        end
        WAIT: begin
          r_wait_cnt <= r_wait_cnt + 32'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed self-checking bench for sram_controller: a 16-bit SRAM model on
// the main instance, plus WAIT_CYCLES=0 and =3 instances for latency.
module tb_sram_controller;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  wire  [15:0] sram_data;
  logic        sram_write_en;

  int n_checks = 0;
  int n_fail   = 0;

  sram_controller u_dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data),
    .ready        (ready),
    .sram_addr    (sram_addr),
    .sram_data    (sram_data),
    .sram_write_en(sram_write_en)
  );

  // SRAM model: captures on clk when write enable is low, drives otherwise.
  // 'park' makes it drive a fixed pattern so a stray DUT driver shows up.
  logic [15:0] mem [0:255];
  logic        park;
  always @(posedge clk) if (!sram_write_en) mem[sram_addr[7:0]] <= sram_data;
  assign sram_data = sram_write_en ? (park ? 16'h5AA5 : mem[sram_addr[7:0]]) : 16'hzzzz;

  // Latency-only instances; their SRAM returns 0x5A00 ^ half-address.
  logic        rd_en0;
  logic        rd_en3;
  logic        alt_zero;
  logic [31:0] alt_addr;
  logic [31:0] alt_wdata;
  logic [31:0] read_data0, read_data3;
  logic        ready0, ready3;
  logic [17:0] sram_addr0, sram_addr3;
  wire  [15:0] sram_data0, sram_data3;
  logic        sram_we0, sram_we3;

  sram_controller #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .wr_en(alt_zero), .rd_en(rd_en0), .address(alt_addr),
    .write_data(alt_wdata), .read_data(read_data0), .ready(ready0),
    .sram_addr(sram_addr0), .sram_data(sram_data0), .sram_write_en(sram_we0)
  );
  sram_controller #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .wr_en(alt_zero), .rd_en(rd_en3), .address(alt_addr),
    .write_data(alt_wdata), .read_data(read_data3), .ready(ready3),
    .sram_addr(sram_addr3), .sram_data(sram_data3), .sram_write_en(sram_we3)
  );
  assign sram_data0 = sram_we0 ? (16'(sram_addr0) ^ 16'h5A00) : 16'hzzzz;
  assign sram_data3 = sram_we3 ? (16'(sram_addr3) ^ 16'h5A00) : 16'hzzzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge with the controller idle. Holds the
  // request until the edge that ends the ready cycle, recording the bus in
  // the first two cycles after the request edge.
  task automatic do_op(input logic we, input logic re, input logic [31:0] addr,
                       input logic [31:0] data, output int lat, output logic r0,
                       output logic [17:0] a_lo, output logic [17:0] a_hi,
                       output logic [15:0] d_lo, output logic [15:0] d_hi,
                       output logic we_lo, output logic we_hi);
    wr_en = we; rd_en = re; address = addr; write_data = data;
    lat = -1; r0 = 1'b1; a_lo = '0; a_hi = '0; d_lo = '0; d_hi = '0;
    we_lo = 1'b1; we_hi = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) r0 = ready;
      if (c == 1) begin a_lo = sram_addr; d_lo = sram_data; we_lo = sram_write_en; end
      if (c == 2) begin a_hi = sram_addr; d_hi = sram_data; we_hi = sram_write_en; end
      if (c > 0 && ready) begin lat = c; break; end
    end
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic measure_alt(input int which, output int lat, output logic [31:0] rd);
    if (which == 0) rd_en0 = 1'b1; else rd_en3 = 1'b1;
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c > 0 && ((which == 0) ? ready0 : ready3)) begin lat = c; break; end
    end
    @(posedge clk); #1;
    rd_en0 = 1'b0; rd_en3 = 1'b0;
    rd = (which == 0) ? read_data0 : read_data3;
  endtask

  int          lat;
  logic        r0, we_lo, we_hi;
  logic [17:0] a_lo, a_hi;
  logic [15:0] d_lo, d_hi;
  logic [31:0] rd;

  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0; park = 1'b1;
    rd_en0 = 1'b0; rd_en3 = 1'b0; alt_zero = 1'b0; alt_addr = 32'd1024; alt_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_we", 32'(sram_write_en), 32'd1);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_bus_free", 32'(sram_data), 32'h5AA5);
    check("rst_rdata", read_data, 32'd0);
    rst = 1'b1; park = 1'b0;
    @(posedge clk); #1;

    // Write 0xDEADBEEF to word 0
    do_op(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, lat, r0, a_lo, a_hi, d_lo, d_hi, we_lo, we_hi);
    check("wr_req_ready", 32'(r0), 32'd0);
    check("wr_latency", 32'(lat), 32'd4);
    check("wr_addr_lo", 32'(a_lo), 32'd0);
    check("wr_addr_hi", 32'(a_hi), 32'd1);
    check("wr_we_lo", 32'(we_lo), 32'd0);
    check("wr_we_hi", 32'(we_hi), 32'd0);
    check("wr_data_lo", 32'(d_lo), 32'hBEEF);
    check("wr_data_hi", 32'(d_hi), 32'hDEAD);
    check("wr_mem0", 32'(mem[0]), 32'hBEEF);
    check("wr_mem1", 32'(mem[1]), 32'hDEAD);
    check("wr_rdata_kept", read_data, 32'd0);

    // Read it back; request held through the ready cycle must not re-issue
    do_op(1'b0, 1'b1, 32'd1024, 32'h0, lat, r0, a_lo, a_hi, d_lo, d_hi, we_lo, we_hi);
    check("rd_latency", 32'(lat), 32'd4);
    check("rd_addr_lo", 32'(a_lo), 32'd0);
    check("rd_addr_hi", 32'(a_hi), 32'd1);
    check("rd_we_lo", 32'(we_lo), 32'd1);
    check("rd_we_hi", 32'(we_hi), 32'd1);
    check("rd_data", read_data, 32'hDEADBEEF);
    @(negedge clk);
    check("no_reissue_ready", 32'(ready), 32'd1);
    check("no_reissue_addr", 32'(sram_addr), 32'd0);
    check("rd_data_hold", read_data, 32'hDEADBEEF);
    @(posedge clk); #1;

    // Address mapping: byte 1036 -> word 3 -> half-words 6, 7
    do_op(1'b1, 1'b0, 32'd1036, 32'hCAFEF00D, lat, r0, a_lo, a_hi, d_lo, d_hi, we_lo, we_hi);
    check("map_addr_lo", 32'(a_lo), 32'd6);
    check("map_addr_hi", 32'(a_hi), 32'd7);
    check("map_mem6", 32'(mem[6]), 32'hF00D);
    check("map_mem7", 32'(mem[7]), 32'hCAFE);

    // Simultaneous wr_en/rd_en: the write wins
    do_op(1'b1, 1'b1, 32'd1028, 32'h12345678, lat, r0, a_lo, a_hi, d_lo, d_hi, we_lo, we_hi);
    check("both_we_lo", 32'(we_lo), 32'd0);
    check("both_addr_lo", 32'(a_lo), 32'd2);
    check("both_mem2", 32'(mem[2]), 32'h5678);
    check("both_mem3", 32'(mem[3]), 32'h1234);
    check("both_rdata_kept", read_data, 32'hDEADBEEF);

    do_op(1'b0, 1'b1, 32'd1036, 32'h0, lat, r0, a_lo, a_hi, d_lo, d_hi, we_lo, we_hi);
    check("map_rd_data", read_data, 32'hCAFEF00D);

    // Address below the window
    do_op(1'b0, 1'b1, 32'd0, 32'h0, lat, r0, a_lo, a_hi, d_lo, d_hi, we_lo, we_hi);
`ifdef SRAM_CTRL_BOUNDS_CHECK_EN
    check("oob_latency", 32'(lat), 32'd1);
    check("oob_addr", 32'(a_lo), 32'd0);
    check("oob_we", 32'(we_lo), 32'd1);
    check("oob_rdata", read_data, 32'd0);
`else
    check("wrap_latency", 32'(lat), 32'd4);
    check("wrap_addr_lo", 32'(a_lo), 32'h3FE00);
    check("wrap_addr_hi", 32'(a_hi), 32'h3FE01);
    check("wrap_rdata", read_data, 32'hDEADBEEF);
`endif

    // Reset for two cycles in the middle of a write's first half
    wr_en = 1'b1; address = 32'd1040; write_data = 32'h11112222;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_low_addr", 32'(sram_addr), 32'd8);
    check("mid_low_ready", 32'(ready), 32'd0);
    rst = 1'b0; wr_en = 1'b0; park = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("in_rst_ready", 32'(ready), 32'd1);
    check("in_rst_we", 32'(sram_write_en), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_ready", 32'(ready), 32'd1);
    check("post_rst_rdata", read_data, 32'd0);
    check("post_rst_addr", 32'(sram_addr), 32'd0);
    check("post_rst_bus_free", 32'(sram_data), 32'h5AA5);
    park = 1'b0;
    @(posedge clk); #1;
    do_op(1'b0, 1'b1, 32'd1024, 32'h0, lat, r0, a_lo, a_hi, d_lo, d_hi, we_lo, we_hi);
    check("post_rst_read", read_data, 32'hDEADBEEF);

    // Latency with WAIT_CYCLES = 0 and 3
    measure_alt(0, lat, rd);
    check("w0_latency", 32'(lat), 32'd3);
    check("w0_rdata", rd, 32'h5A01_5A00);
    measure_alt(3, lat, rd);
    check("w3_latency", 32'(lat), 32'd6);
    check("w3_rdata", rd, 32'h5A01_5A00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
